// File: rtl/cnn_split_2out.sv
// Channel-major stream splitter: the first NUM_CH_NO1 channels of each frame go to
// port no1, the next NUM_CH_NO2 channels go to port no2, then routing wraps to no1.
module cnn_split_2out #(
    parameter int DATA_WIDTH        = 32,
    parameter int CHANNEL_NUM_PIXEL = 612 * 612,
    parameter int NUM_CH_NO1        = 1,
    parameter int NUM_CH_NO2        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out_no1,
    output logic                  valid_out_no1,
    output logic [DATA_WIDTH-1:0] out_no2,
    output logic                  valid_out_no2,
    output logic                  frame_done
);

    localparam int PIX_W  = (CHANNEL_NUM_PIXEL > 1) ? $clog2(CHANNEL_NUM_PIXEL) : 1;
    localparam int CH_MAX = (NUM_CH_NO1 > NUM_CH_NO2) ? NUM_CH_NO1 : NUM_CH_NO2;
    localparam int CH_W   = (CH_MAX > 1) ? $clog2(CH_MAX) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(CHANNEL_NUM_PIXEL - 1);
    localparam logic [CH_W-1:0]  CH_LAST_NO1 = CH_W'(NUM_CH_NO1 - 1);
    localparam logic [CH_W-1:0]  CH_LAST_NO2 = CH_W'(NUM_CH_NO2 - 1);
    localparam logic [PIX_W-1:0] PIX_ONE     = PIX_W'(1);
    localparam logic [CH_W-1:0]  CH_ONE      = CH_W'(1);

    typedef enum logic [0:0] {
        ROUTE_NO1 = 1'b0,
        ROUTE_NO2 = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
    logic [DATA_WIDTH-1:0] out_no1_q, out_no1_d;
    logic [DATA_WIDTH-1:0] out_no2_q, out_no2_d;
    logic                  valid_out_no1_q, valid_out_no1_d;
    logic                  valid_out_no2_q, valid_out_no2_d;
    logic                  frame_done_q, frame_done_d;
    logic                  last_pix_s;

    assign last_pix_s = (pix_cnt_q == PIX_LAST);

    // Next-state, counter and output-register computation; routing uses the pre-update state.
    always_comb begin
        state_d         = state_q;
        pix_cnt_d       = pix_cnt_q;
        ch_cnt_d        = ch_cnt_q;
        out_no1_d       = out_no1_q;
        out_no2_d       = out_no2_q;
        valid_out_no1_d = 1'b0;
        valid_out_no2_d = 1'b0;
        frame_done_d    = 1'b0;

        if (valid_in) begin
            if (last_pix_s) begin
                pix_cnt_d = {PIX_W{1'b0}};
            end else begin
                pix_cnt_d = pix_cnt_q + PIX_ONE;
            end

            case (state_q)
                ROUTE_NO1: begin
                    out_no1_d       = in;
                    valid_out_no1_d = 1'b1;
                    if (last_pix_s) begin
                        if (ch_cnt_q == CH_LAST_NO1) begin
                            ch_cnt_d = {CH_W{1'b0}};
                            state_d  = ROUTE_NO2;
                        end else begin
                            ch_cnt_d = ch_cnt_q + CH_ONE;
                        end
                    end else begin
                        ch_cnt_d = ch_cnt_q;
                    end
                end
                ROUTE_NO2: begin
                    out_no2_d       = in;
                    valid_out_no2_d = 1'b1;
                    if (last_pix_s) begin
                        if (ch_cnt_q == CH_LAST_NO2) begin
                            ch_cnt_d     = {CH_W{1'b0}};
                            state_d      = ROUTE_NO1;
                            frame_done_d = 1'b1;
                        end else begin
                            ch_cnt_d = ch_cnt_q + CH_ONE;
                        end
                    end else begin
                        ch_cnt_d = ch_cnt_q;
                    end
                end
                default: begin
                    // Unreachable encoding: resynchronise to the start of a frame.
                    state_d   = ROUTE_NO1;
                    pix_cnt_d = {PIX_W{1'b0}};
                    ch_cnt_d  = {CH_W{1'b0}};
                end
            endcase
        end else begin
            pix_cnt_d = pix_cnt_q;
            ch_cnt_d  = ch_cnt_q;
        end
    end

    // State, counters and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ROUTE_NO1;
            pix_cnt_q       <= {PIX_W{1'b0}};
            ch_cnt_q        <= {CH_W{1'b0}};
            out_no1_q       <= {DATA_WIDTH{1'b0}};
            out_no2_q       <= {DATA_WIDTH{1'b0}};
            valid_out_no1_q <= 1'b0;
            valid_out_no2_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pix_cnt_q       <= pix_cnt_d;
            ch_cnt_q        <= ch_cnt_d;
            out_no1_q       <= out_no1_d;
            out_no2_q       <= out_no2_d;
            valid_out_no1_q <= valid_out_no1_d;
            valid_out_no2_q <= valid_out_no2_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign out_no1       = out_no1_q;
    assign out_no2       = out_no2_q;
    assign valid_out_no1 = valid_out_no1_q;
    assign valid_out_no2 = valid_out_no2_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_cnn_split_2out.sv
// Self-checking bench for cnn_split_2out: directed scenarios plus randomized traffic,
// compared against a frame-position reference model.
module tb_cnn_split_2out;

    localparam int DW  = 32;
    localparam int P   = 4;
    localparam int N1  = 2;
    localparam int N2  = 1;
    localparam int FRM = (N1 + N2) * P;

    logic          clk;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] in_s;
    logic [DW-1:0] out_no1;
    logic          valid_out_no1;
    logic [DW-1:0] out_no2;
    logic          valid_out_no2;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: pixel index since reset determines the branch.
    int unsigned   m_n;
    logic [DW-1:0] m_out1, m_out2;
    logic          m_v1, m_v2, m_fd;
    int            fd_count;

    cnn_split_2out #(
        .DATA_WIDTH(DW),
        .CHANNEL_NUM_PIXEL(P),
        .NUM_CH_NO1(N1),
        .NUM_CH_NO2(N2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .in(in_s),
        .out_no1(out_no1),
        .valid_out_no1(valid_out_no1),
        .out_no2(out_no2),
        .valid_out_no2(valid_out_no2),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_out1 = '0;
        m_out2 = '0;
        m_v1   = 1'b0;
        m_v2   = 1'b0;
        m_fd   = 1'b0;
    endtask

    task automatic check_all();
        chk("out_no1", out_no1, m_out1);
        chk("valid_no1", {31'd0, valid_out_no1}, {31'd0, m_v1});
        chk("out_no2", out_no2, m_out2);
        chk("valid_no2", {31'd0, valid_out_no2}, {31'd0, m_v2});
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        chk("excl_valid", {31'd0, valid_out_no1 & valid_out_no2}, 32'd0);
        if (frame_done) fd_count++;
    endtask

    // One clock: apply inputs, step model, check registered outputs 1 ns after the edge.
    task automatic drive(input logic v, input logic [DW-1:0] d);
        int unsigned pos;
        valid_in = v;
        in_s     = d;
        @(posedge clk);
        #1;
        m_v1 = 1'b0;
        m_v2 = 1'b0;
        m_fd = 1'b0;
        if (v) begin
            pos = m_n % FRM;
            if (pos < N1 * P) begin
                m_v1   = 1'b1;
                m_out1 = d;
            end else begin
                m_v2   = 1'b1;
                m_out2 = d;
            end
            m_fd = (pos == FRM - 1);
            m_n++;
        end
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic async_reset_pulse();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b1;
        in_s     = 32'h0000_00FF;
        fd_count = 0;
        model_reset();

        // Reset held with active input: outputs must stay zero.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        reset = 1'b1;

        // Continuous frame 0x00..0x0B.
        for (int i = 0; i < 12; i++) drive(1'b1, 32'(i));
        chk("fd_count_frame1", 32'(fd_count), 32'd1);

        // Same frame again with gaps every other cycle.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'(i));
            drive(1'b0, 32'hDEAD_0000 + 32'(i));
        end

        // Back-to-back frames 0x00..0x17.
        fd_count = 0;
        for (int i = 0; i < 24; i++) drive(1'b1, 32'(i));
        chk("fd_count_b2b", 32'(fd_count), 32'd2);

        // Mid-frame reset after pixel 0x05, then a fresh frame 0x20..0x2B.
        for (int i = 0; i < 6; i++) drive(1'b1, 32'(i));
        async_reset_pulse();
        fd_count = 0;
        for (int i = 0; i < 12; i++) drive(1'b1, 32'h20 + 32'(i));
        chk("fd_count_after_rst", 32'(fd_count), 32'd1);
        chk("last_no2_after_rst", out_no2, 32'h2B);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom);
            if ($urandom_range(0, 79) == 0) async_reset_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
